change_dispenser: RTL

- Payout end of the vending machine. Takes the `change[1:0]` code the vending FSM produces and pays it out coin by coin to a coin hopper over a req/ack handshake.
- Tracks the on-board stock of 5- and 10-unit coins.
- Refuses any payout it cannot complete in full.
- Latches a fault if the hopper jams.
- Sits between `vending_machine` (upstream, `change` output) and the hopper actuator driver (downstream).

---
 rtl/vm_pkg.sv | 24 ++
 rtl/change_dispenser_coin_stock.sv | 38 +++
 rtl/change_dispenser.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, change codes and the
// payout state encoding used by change_dispenser.
package vm_pkg;

    // Coin codes driven on coin_out
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    // Change codes produced by vending_machine, in 5-unit steps
    localparam logic [1:0] CHG_0  = 2'b00;
    localparam logic [1:0] CHG_5  = 2'b01;
    localparam logic [1:0] CHG_10 = 2'b10;
    localparam logic [1:0] CHG_15 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        GAP,
        FAULT
    } state_t;

endpackage

// File: rtl/change_dispenser_coin_stock.sv
// Stock counter for one coin denomination: reloads to INIT on reset or
// load, counts down by one per dispensed coin.
module coin_stock #(
    parameter int unsigned INIT  = 0,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: reload has priority over decrement
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CNT_W'(INIT);
        end else if (dec) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= CNT_W'(INIT);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: checks stock, then pays 10s first and 5s after
// over a req/ack hopper handshake, with a sticky jam fault on ack timeout.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int unsigned STOCK5_INIT  = 8,
    parameter int unsigned STOCK10_INIT = 4,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned ACK_TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       change_in,
    input  logic             change_vld,
    output logic             busy,
    output logic             coin_req,
    output logic [1:0]       coin_out,
    input  logic             coin_ack,
    input  logic             refill,
    output logic             done,
    output logic             err,
    output logic             fault,
    output logic [CNT_W-1:0] stock5,
    output logic [CNT_W-1:0] stock10
);

    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [1:0]       amt_q, amt_d;
    logic             plan10_q, plan10_d;
    logic [1:0]       plan5_q, plan5_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             busy_q, busy_d;
    logic             coin_req_q, coin_req_d;
    logic [1:0]       coin_out_q, coin_out_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             fault_q, fault_d;

    logic             load;
    logic             dec5;
    logic             dec10;
    logic             n10;
    logic [1:0]       n5;

    coin_stock #(.INIT(STOCK5_INIT), .CNT_W(CNT_W)) u_stock5 (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .dec   (dec5),
        .count (stock5)
    );

    coin_stock #(.INIT(STOCK10_INIT), .CNT_W(CNT_W)) u_stock10 (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .dec   (dec10),
        .count (stock10)
    );

    // Payout FSM next-state, plan bookkeeping and registered output values
    always_comb begin
        state_d    = state_q;
        amt_d      = amt_q;
        plan10_d   = plan10_q;
        plan5_d    = plan5_q;
        tmr_d      = tmr_q;
        busy_d     = busy_q;
        coin_req_d = coin_req_q;
        coin_out_d = coin_out_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        fault_d    = fault_q;
        load       = 1'b0;
        dec5       = 1'b0;
        dec10      = 1'b0;

        // amt>>1 is at most one, so min() reduces to "a 10 is wanted and one is left"
        n10 = amt_q[1] && (stock10 != '0);
        n5  = amt_q - {n10, 1'b0};

        unique case (state_q)
            IDLE: begin
                load = refill;
                if (change_vld) begin
                    amt_d   = change_in;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (CNT_W'(n5) > stock5) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (amt_q == CHG_0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    plan10_d = n10;
                    plan5_d  = n5;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (!coin_req_q) begin
                    // First REQ cycle raises the request with the coin chosen once
                    coin_req_d = 1'b1;
                    coin_out_d = plan10_q ? COIN_10 : COIN_5;
                    tmr_d      = '0;
                end else if (coin_ack) begin
                    if (coin_out_q == COIN_10) begin
                        dec10    = 1'b1;
                        plan10_d = 1'b0;
                    end else begin
                        dec5    = 1'b1;
                        plan5_d = plan5_q - 1'b1;
                    end
                    coin_req_d = 1'b0;
                    coin_out_d = COIN_NONE;
                    state_d    = GAP;
                end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    coin_req_d = 1'b0;
                    coin_out_d = COIN_NONE;
                    fault_d    = 1'b1;
                    state_d    = FAULT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            GAP: begin
                if (!plan10_q && (plan5_q == '0)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            FAULT: begin
                busy_d  = 1'b1;
                fault_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            amt_q      <= '0;
            plan10_q   <= 1'b0;
            plan5_q    <= '0;
            tmr_q      <= '0;
            busy_q     <= 1'b0;
            coin_req_q <= 1'b0;
            coin_out_q <= COIN_NONE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            amt_q      <= amt_d;
            plan10_q   <= plan10_d;
            plan5_q    <= plan5_d;
            tmr_q      <= tmr_d;
            busy_q     <= busy_d;
            coin_req_q <= coin_req_d;
            coin_out_q <= coin_out_d;
            done_q     <= done_d;
            err_q      <= err_d;
            fault_q    <= fault_d;
        end
    end

    assign busy     = busy_q;
    assign coin_req = coin_req_q;
    assign coin_out = coin_out_q;
    assign done     = done_q;
    assign err      = err_q;
    assign fault    = fault_q;

endmodule
